ram_init_loader: RTL
====================

RAM_INIT_LOADER -- requirements
Module: ram_init_loader

Interface
REQ-001 SHALL have parameter addr_width_g, default 11, address width of the downstream single-port RAM.
REQ-002 SHALL have parameter data_width_g, default 8, RAM data width.
REQ-003 SHALL have parameter fill_value_g, default 0, word written during the power-up clear.
REQ-004 SHALL have port clock  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port dl_active  input  1  a download session is in progress.
REQ-007 SHALL have port dl_wr  input  1  one-cycle strobe: a download word is valid.
REQ-008 SHALL have port dl_addr  input  addr_width_g  download word address.
REQ-009 SHALL have port dl_data  input  data_width_g  download word.
REQ-010 SHALL have port cpu_cs  input  1  CPU selects the RAM this cycle.
REQ-011 SHALL have port cpu_wren  input  1  CPU write when high, read when low.
REQ-012 SHALL have port cpu_addr  input  addr_width_g  CPU address.
REQ-013 SHALL have port cpu_data  input  data_width_g  CPU write data.
REQ-014 SHALL have port ram_clken  output  1  RAM clock enable.
REQ-015 SHALL have port ram_wren  output  1  RAM write enable.
REQ-016 SHALL have port ram_address  output  addr_width_g  RAM address.
REQ-017 SHALL have port ram_data  output  data_width_g  RAM write data.
REQ-018 SHALL have port cpu_wait  output  1  CPU access refused this cycle.
REQ-019 SHALL have port ready  output  1  clear is finished and the CPU owns the RAM.
REQ-020 SHALL have port dl_count  output  addr_width_g+1  number of download words accepted in the current session.

Function
REQ-021 SHALL implement FSM states CLEAR, RUN and LOAD.
REQ-022 SHALL register all ram_* outputs, so each request reaches the RAM port one cycle later.
REQ-023 SHALL, in CLEAR, write fill_value_g to addresses 0..2^addr_width_g-1, one per cycle, in ascending order.
REQ-024 SHALL go from CLEAR to RUN on the cycle after the write to the last address is issued, asserting ready that cycle.
REQ-025 SHALL, in RUN, forward a cpu_cs access as clken=1, wren=cpu_wren, address=cpu_addr, data=cpu_data; without cpu_cs, ram_clken=0.
REQ-026 SHALL go to LOAD when dl_active is high in RUN or CLEAR; a CLEAR abandoned this way SHALL NOT resume.
REQ-027 SHALL clear dl_count to 0 on entry to LOAD.
REQ-028 SHALL, in LOAD, forward each dl_wr as a RAM write of dl_data to dl_addr and increment dl_count.
REQ-029 SHALL hold dl_count saturated at 2^addr_width_g.
REQ-030 SHALL, in LOAD, keep ram_clken=0 on cycles without dl_wr.
REQ-031 SHALL go from LOAD to RUN on the cycle after dl_active falls; a dl_wr arriving in that same cycle SHALL still be written.
REQ-032 SHALL drive cpu_wait = cpu_cs AND state!=RUN, combinationally; CPU accesses in CLEAR or LOAD are dropped.
REQ-033 SHALL drive ready=1 in RUN only.
REQ-034 SHALL NOT generate a RAM write for cpu_wren without cpu_cs, or for dl_wr outside LOAD.

Reset
REQ-035 SHALL, on reset, enter CLEAR with clear address 0, and set ram_clken=0, ram_wren=0, ram_address=0, ram_data=0, ready=0, dl_count=0.
REQ-036 SHALL, on reset asserted mid-CLEAR or mid-LOAD, abort the operation and restart CLEAR from address 0.

Structure
REQ-037 SHALL define the FSM state encodings and the default fill value as constants in the shared memory-controller include.
REQ-038 SHALL contain no sub-module; the clear-address counter and dl_count are local registers, and the RAM is instantiated by the parent.

Verification
REQ-039 SHALL cover: reset released, addr_width_g=4 -> 16 consecutive writes of 0 to addresses 0..15, then ready=1 on cycle 17.
REQ-040 SHALL cover: RUN, cpu_cs=1, cpu_wren=1, addr 0x123, data 0x5A -> next cycle ram_clken=1, ram_wren=1, ram_address=0x123, ram_data=0x5A, cpu_wait=0.
REQ-041 SHALL cover: dl_active raised at clear address 7 -> LOAD, ready=0, no further fill writes; 3 dl_wr then dl_active low -> dl_count=3, then RUN.
REQ-042 SHALL cover: LOAD with cpu_cs=1 and dl_wr in the same cycle -> cpu_wait=1, only the download write reaches the RAM.
REQ-043 SHALL cover: dl_wr in the cycle dl_active falls, addr 0x7FF, data 0xC3 -> write issued, then RUN.
REQ-044 SHALL cover: reset pulsed mid-LOAD -> dl_count=0, CLEAR restarts at address 0, ready=0.

Source files
------------

// File: rtl/ram_init_loader_pkg.sv
// Shared memory-controller constants: loader FSM state encodings and the default clear word.
`default_nettype none

package ram_init_loader_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int DEFAULT_FILL = 0;

endpackage

`default_nettype wire

// File: rtl/ram_init_loader.sv
// RAM front-end: clears the RAM after reset, then arbitrates between CPU accesses and
// download sessions; all RAM-side signals are registered.
`default_nettype none

module ram_init_loader
  import ram_init_loader_pkg::*;
#(
  parameter int addr_width_g = 11,
  parameter int data_width_g = 8,
  parameter int fill_value_g = DEFAULT_FILL
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dl_active,
  input  logic                    dl_wr,
  input  logic [addr_width_g-1:0] dl_addr,
  input  logic [data_width_g-1:0] dl_data,
  input  logic                    cpu_cs,
  input  logic                    cpu_wren,
  input  logic [addr_width_g-1:0] cpu_addr,
  input  logic [data_width_g-1:0] cpu_data,
  output logic                    ram_clken,
  output logic                    ram_wren,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  output logic                    cpu_wait,
  output logic                    ready,
  output logic [addr_width_g:0]   dl_count
);

  localparam logic [addr_width_g:0]   DL_MAX = {1'b1, {addr_width_g{1'b0}}};
  localparam logic [data_width_g-1:0] FILL   = data_width_g'(fill_value_g);

  state_t                  state_q, state_d;
  logic [addr_width_g-1:0] clear_addr_q, clear_addr_d;
  logic [addr_width_g:0]   dl_count_q, dl_count_d;
  logic                    ram_clken_q, ram_clken_d;
  logic                    ram_wren_q, ram_wren_d;
  logic [addr_width_g-1:0] ram_address_q, ram_address_d;
  logic [data_width_g-1:0] ram_data_q, ram_data_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= CLEAR;
      clear_addr_q  <= '0;
      dl_count_q    <= '0;
      ram_clken_q   <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      clear_addr_q  <= clear_addr_d;
      dl_count_q    <= dl_count_d;
      ram_clken_q   <= ram_clken_d;
      ram_wren_q    <= ram_wren_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clear_addr_d  = clear_addr_q;
    dl_count_d    = dl_count_q;
    ram_clken_d   = 1'b0;
    ram_wren_d    = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;

    case (state_q)
      CLEAR: begin
        // A download pre-empts the clear for good; its image owns the RAM afterwards.
        if (dl_active) begin
          state_d    = LOAD;
          dl_count_d = '0;
        end else begin
          ram_clken_d   = 1'b1;
          ram_wren_d    = 1'b1;
          ram_address_d = clear_addr_q;
          ram_data_d    = FILL;
          clear_addr_d  = clear_addr_q + 1'b1;
          if (clear_addr_q == '1) state_d = RUN;
        end
      end
      RUN: begin
        if (cpu_cs) begin
          ram_clken_d   = 1'b1;
          ram_wren_d    = cpu_wren;
          ram_address_d = cpu_addr;
          ram_data_d    = cpu_data;
        end
        if (dl_active) begin
          state_d    = LOAD;
          dl_count_d = '0;
        end
      end
      LOAD: begin
        if (dl_wr) begin
          ram_clken_d   = 1'b1;
          ram_wren_d    = 1'b1;
          ram_address_d = dl_addr;
          ram_data_d    = dl_data;
          if (dl_count_q != DL_MAX) dl_count_d = dl_count_q + 1'b1;
        end
        if (!dl_active) state_d = RUN;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign ram_clken   = ram_clken_q;
  assign ram_wren    = ram_wren_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign dl_count    = dl_count_q;
  assign ready       = (state_q == RUN);
  assign cpu_wait    = cpu_cs && (state_q != RUN);

endmodule

`default_nettype wire
